vend_ctrl: RTL and testbench

Transaction sequencer for the vending machine. It accepts coin and button events, keeps the credit balance and the selected product, and drives the mode and value inputs of the seven-segment display driver (`price`, `money`, `display_hello`, `display_price`). It also issues the vend command and paces change dispensing one unit at a time. It sits between the debounced front-panel inputs and the display driver and dispense actuators.

---
 rtl/vend_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_vend_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// Vending transaction sequencer: credit, selection, vend strobe and paced change output.
// All outputs registered, one cycle after the triggering event; events arriving while busy are rejected or ignored.
module vend_ctrl #(
   parameter int PRICE_SHOW_CYCLES = 100,
   parameter int IDLE_TIMEOUT      = 1000,
   parameter int MONEY_MAX         = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   input  logic       sel_valid,
   input  logic [2:0] sel_item,
   input  logic       buy,
   input  logic       cancel,
   output logic [3:0] price,
   output logic [7:0] money,
   output logic       display_hello,
   output logic       display_price,
   output logic       vend_valid,
   output logic [2:0] vend_item,
   output logic       change_pulse,
   output logic       coin_reject,
   output logic       busy
);

   localparam int TW = (PRICE_SHOW_CYCLES > 1) ? $clog2(PRICE_SHOW_CYCLES) : 1;
   localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(PRICE_SHOW_CYCLES - 1);
   localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
   localparam logic [8:0]    MONEY_CAP  = 9'(MONEY_MAX);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRICE,
      S_COLLECT,
      S_VEND,
      S_CHANGE
   } state_t;

   state_t        state, state_nxt;
   logic [7:0]    money_nxt;
   logic [3:0]    price_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [IW-1:0] idle_cnt, idle_nxt;
   logic          vend_valid_nxt;
   logic [2:0]    vend_item_nxt;
   logic          change_nxt;
   logic          reject_nxt;

   logic [7:0]    coin_val;
   logic [8:0]    coin_sum;
   logic          coin_fits;
   logic          sel_ok;
   logic [7:0]    cost_cur;
   logic [7:0]    remain;
   logic          can_buy;
   logic          quit;

   function automatic logic [7:0] item_cost(input logic [2:0] item);
      case (item)
         3'd1:    return 8'd2;
         3'd2:    return 8'd4;
         3'd3:    return 8'd6;
         3'd4:    return 8'd10;
         default: return 8'd0;
      endcase
   endfunction

   always_comb begin
      coin_val = 8'd0;
      case (coin_type)
         2'd0:    coin_val = 8'd1;
         2'd1:    coin_val = 8'd2;
         2'd2:    coin_val = 8'd10;
         default: coin_val = 8'd0;
      endcase
   end

   // Sum is formed in 9 bits so the ceiling check cannot be fooled by wrap-around.
   assign coin_sum  = {1'b0, money} + {1'b0, coin_val};
   assign coin_fits = (coin_type != 2'd3) && (coin_sum <= MONEY_CAP);
   assign sel_ok    = sel_valid && (sel_item >= 3'd1) && (sel_item <= 3'd4);
   assign cost_cur  = item_cost(price[2:0]);
   assign remain    = money - cost_cur;
   assign can_buy   = (price != 4'd0) && (money >= cost_cur);
   // The inactivity timeout behaves exactly like a cancel, including winning the cycle.
   assign quit      = cancel || ((state == S_COLLECT) && (idle_cnt == IDLE_LAST));

   always_comb begin
      state_nxt      = state;
      money_nxt      = money;
      price_nxt      = price;
      timer_nxt      = timer;
      idle_nxt       = idle_cnt;
      vend_valid_nxt = 1'b0;
      vend_item_nxt  = 3'd0;
      change_nxt     = 1'b0;
      reject_nxt     = 1'b0;

      case (state)
         S_IDLE: begin
            if (sel_ok) begin
               state_nxt  = S_PRICE;
               price_nxt  = {1'b0, sel_item};
               timer_nxt  = TIMER_LOAD;
               reject_nxt = coin_valid;
            end else if (coin_valid) begin
               if (coin_fits) begin
                  money_nxt = coin_sum[7:0];
                  state_nxt = S_COLLECT;
                  idle_nxt  = '0;
               end else begin
                  reject_nxt = 1'b1;
               end
            end
         end

         S_PRICE, S_COLLECT: begin
            if (state == S_PRICE) begin
               if (timer == '0) begin
                  state_nxt = S_COLLECT;
                  idle_nxt  = '0;
               end else begin
                  timer_nxt = timer - TW'(1);
               end
            end else begin
               idle_nxt = idle_cnt + IW'(1);
            end

            // cancel and buy claim the cycle here even when they have no effect.
            if (quit) begin
               price_nxt  = 4'd0;
               reject_nxt = coin_valid;
               if (money != 8'd0) begin
                  state_nxt  = S_CHANGE;
                  change_nxt = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else if (buy) begin
               reject_nxt = coin_valid;
               if (can_buy) begin
                  state_nxt      = S_VEND;
                  vend_valid_nxt = 1'b1;
                  vend_item_nxt  = price[2:0];
               end
            end else if (sel_ok) begin
               state_nxt  = S_PRICE;
               price_nxt  = {1'b0, sel_item};
               timer_nxt  = TIMER_LOAD;
               reject_nxt = coin_valid;
            end else if (coin_valid) begin
               if (coin_fits) begin
                  money_nxt = coin_sum[7:0];
                  idle_nxt  = '0;
               end else begin
                  reject_nxt = 1'b1;
               end
            end
         end

         S_VEND: begin
            reject_nxt = coin_valid;
            money_nxt  = remain;
            price_nxt  = 4'd0;
            if (remain != 8'd0) begin
               state_nxt  = S_CHANGE;
               change_nxt = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end

         S_CHANGE: begin
            reject_nxt = coin_valid;
            // change_pulse high marks the pulse half of each pulse/gap pair.
            if (change_pulse) begin
               money_nxt = money - 8'd1;
            end else if (money == 8'd0) begin
               state_nxt = S_IDLE;
            end else begin
               change_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         money         <= 8'd0;
         price         <= 4'd0;
         timer         <= '0;
         idle_cnt      <= '0;
         display_hello <= 1'b1;
         display_price <= 1'b0;
         vend_valid    <= 1'b0;
         vend_item     <= 3'd0;
         change_pulse  <= 1'b0;
         coin_reject   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         money         <= money_nxt;
         price         <= price_nxt;
         timer         <= timer_nxt;
         idle_cnt      <= idle_nxt;
         display_hello <= (state_nxt == S_IDLE);
         display_price <= (state_nxt == S_PRICE);
         vend_valid    <= vend_valid_nxt;
         vend_item     <= vend_item_nxt;
         change_pulse  <= change_nxt;
         coin_reject   <= reject_nxt;
         busy          <= (state_nxt == S_VEND) || (state_nxt == S_CHANGE);
      end
   end

endmodule

// File: tb/tb_vend_ctrl.sv
// Randomized and directed bench for vend_ctrl against a transaction-level reference model.
module tb_vend_ctrl;

   localparam int P    = 100;
   localparam int T    = 1000;
   localparam int MAXM = 200;

   localparam int M_IDLE    = 0;
   localparam int M_PRICE   = 1;
   localparam int M_COLLECT = 2;
   localparam int M_VEND    = 3;
   localparam int M_CHANGE  = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic       sel_valid;
   logic [2:0] sel_item;
   logic       buy;
   logic       cancel;
   logic [3:0] price;
   logic [7:0] money;
   logic       display_hello;
   logic       display_price;
   logic       vend_valid;
   logic [2:0] vend_item;
   logic       change_pulse;
   logic       coin_reject;
   logic       busy;

   always #5 clk = ~clk;

   vend_ctrl #(
      .PRICE_SHOW_CYCLES (P),
      .IDLE_TIMEOUT      (T),
      .MONEY_MAX         (MAXM)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .coin_valid    (coin_valid),
      .coin_type     (coin_type),
      .sel_valid     (sel_valid),
      .sel_item      (sel_item),
      .buy           (buy),
      .cancel        (cancel),
      .price         (price),
      .money         (money),
      .display_hello (display_hello),
      .display_price (display_price),
      .vend_valid    (vend_valid),
      .vend_item     (vend_item),
      .change_pulse  (change_pulse),
      .coin_reject   (coin_reject),
      .busy          (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: mode plus remaining-cycle budgets for the price screen and refund.
   int m_mode, m_money, m_price, m_show, m_quiet, m_chg;
   bit m_rej;

   function automatic int coin_units(input int t);
      case (t)
         0:       return 1;
         1:       return 2;
         2:       return 10;
         default: return -1;
      endcase
   endfunction

   function automatic int cost_of(input int i);
      case (i)
         1:       return 2;
         2:       return 4;
         3:       return 6;
         4:       return 10;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_money = 0; m_price = 0;
      m_show = 0; m_quiet = 0; m_chg = 0; m_rej = 0;
   endtask

   task automatic start_refund();
      m_price = 0;
      if (m_money > 0) begin
         m_mode = M_CHANGE;
         m_chg  = 2 * m_money;
      end else begin
         m_mode = M_IDLE;
      end
   endtask

   task automatic model_step();
      int  v, item, mode0;
      bit  selok, fits, tmo;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_rej = 0;
      mode0 = m_mode;
      item  = int'(sel_item);
      selok = sel_valid && item >= 1 && item <= 4;
      v     = coin_units(int'(coin_type));
      fits  = (v >= 0) && (m_money + v <= MAXM);
      case (mode0)
         M_IDLE: begin
            if (selok) begin
               m_mode = M_PRICE; m_price = item; m_show = P; m_rej = coin_valid;
            end else if (coin_valid) begin
               if (fits) begin
                  m_money += v; m_mode = M_COLLECT; m_quiet = 0;
               end else m_rej = 1;
            end
         end
         M_PRICE, M_COLLECT: begin
            tmo = 0;
            if (mode0 == M_PRICE) begin
               m_show--;
               if (m_show == 0) begin
                  m_mode = M_COLLECT; m_quiet = 0;
               end
            end else begin
               tmo = (m_quiet + 1 >= T);
               m_quiet++;
            end
            if (cancel || tmo) begin
               m_rej = coin_valid;
               start_refund();
            end else if (buy) begin
               m_rej = coin_valid;
               if (m_price != 0 && m_money >= cost_of(m_price)) m_mode = M_VEND;
            end else if (selok) begin
               m_mode = M_PRICE; m_price = item; m_show = P; m_rej = coin_valid;
            end else if (coin_valid) begin
               if (fits) begin
                  m_money += v; m_quiet = 0;
               end else m_rej = 1;
            end
         end
         M_VEND: begin
            m_rej = coin_valid;
            m_money -= cost_of(m_price);
            start_refund();
         end
         default: begin
            m_rej = coin_valid;
            if (m_chg % 2 == 0) m_money--;
            m_chg--;
            if (m_chg == 0) m_mode = M_IDLE;
         end
      endcase
   endtask

   int n_pulse = 0, n_vend = 0, n_rej = 0, n_dprice = 0, last_item = 0;

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("price", price, m_price);
      chk("money", money, m_money);
      chk("display_hello", display_hello, m_mode == M_IDLE);
      chk("display_price", display_price, m_mode == M_PRICE);
      chk("vend_valid", vend_valid, m_mode == M_VEND);
      chk("vend_item", vend_item, (m_mode == M_VEND) ? m_price : 0);
      chk("change_pulse", change_pulse, (m_mode == M_CHANGE) && (m_chg % 2 == 0));
      chk("coin_reject", coin_reject, m_rej);
      chk("busy", busy, (m_mode == M_VEND) || (m_mode == M_CHANGE));
      if (change_pulse) n_pulse++;
      if (coin_reject) n_rej++;
      if (display_price) n_dprice++;
      if (vend_valid) begin
         n_vend++;
         last_item = int'(vend_item);
      end
   endtask

   task automatic clear_in();
      cancel = 0; buy = 0; sel_valid = 0; sel_item = 0; coin_valid = 0; coin_type = 0;
   endtask

   // One event cycle followed by one quiet cycle.
   task automatic ev(input bit c, input bit b, input bit s, input int item, input bit cv, input int ct);
      cancel = c; buy = b; sel_valid = s; sel_item = item[2:0];
      coin_valid = cv; coin_type = ct[1:0];
      tick();
      clear_in();
      tick();
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      for (int k = 0; k < max_cyc && !display_hello; k++) tick();
      chk(tag, display_hello, 1);
   endtask

   int p0, v0, r0, d0;

   initial begin
      model_reset();
      clear_in();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      chk("rst_money", money, 0);
      chk("rst_hello", display_hello, 1);
      chk("rst_price", price, 0);
      chk("rst_busy", busy, 0);

      // 1-yuan coin, select, price screen duration, underfunded buy
      ev(0, 0, 0, 0, 1, 1);
      chk("t1_money", money, 2);
      d0 = n_dprice;
      ev(0, 0, 1, 2, 0, 0);
      for (int k = 0; k < 300 && display_price; k++) tick();
      chk("t1_price_cycles", n_dprice - d0, P);
      v0 = n_vend;
      ev(0, 1, 0, 0, 0, 0);
      chk("t1_no_vend", n_vend - v0, 0);
      chk("t1_money_kept", money, 2);
      ev(1, 0, 0, 0, 0, 0);
      wait_idle("t1_idle", 50);

      // funded purchase with change
      p0 = n_pulse; v0 = n_vend;
      ev(0, 0, 1, 4, 0, 0);
      ev(0, 0, 0, 0, 1, 2);
      ev(0, 0, 0, 0, 1, 1);
      chk("t2_money", money, 12);
      ev(0, 1, 0, 0, 0, 0);
      wait_idle("t2_idle", 50);
      chk("t2_vends", n_vend - v0, 1);
      chk("t2_item", last_item, 4);
      chk("t2_pulses", n_pulse - p0, 2);
      chk("t2_money_end", money, 0);

      // credit ceiling
      for (int k = 0; k < 20; k++) ev(0, 0, 0, 0, 1, 2);
      chk("t3_money_max", money, 200);
      r0 = n_rej;
      ev(0, 0, 0, 0, 1, 0);
      chk("t3_reject", n_rej - r0, 1);
      chk("t3_money_kept", money, 200);
      ev(1, 0, 0, 0, 0, 0);
      wait_idle("t3_idle", 500);

      // cancel beats buy and coin in the same cycle
      for (int k = 0; k < 3; k++) ev(0, 0, 0, 0, 1, 1);
      chk("t4_money", money, 6);
      p0 = n_pulse; v0 = n_vend; r0 = n_rej;
      ev(1, 1, 0, 0, 1, 0);
      wait_idle("t4_idle", 50);
      chk("t4_reject", n_rej - r0, 1);
      chk("t4_no_vend", n_vend - v0, 0);
      chk("t4_pulses", n_pulse - p0, 6);

      // inactivity refund
      ev(0, 0, 0, 0, 1, 1);
      ev(0, 0, 0, 0, 1, 0);
      chk("t5_money", money, 3);
      p0 = n_pulse;
      wait_idle("t5_timeout_idle", T + 100);
      chk("t5_pulses", n_pulse - p0, 3);

      // reset in the middle of a refund
      ev(0, 0, 0, 0, 1, 2);
      ev(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      chk("t6_money", money, 0);
      chk("t6_hello", display_hello, 1);
      p0 = n_pulse;
      for (int k = 0; k < 20; k++) tick();
      chk("t6_no_pulses", n_pulse - p0, 0);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         bit c, b, s, cv;
         int it, ct;
         c  = ($urandom_range(99) < 4);
         b  = ($urandom_range(99) < 12);
         s  = ($urandom_range(99) < 15);
         cv = ($urandom_range(99) < 45);
         it = $urandom_range(7);
         ct = $urandom_range(3);
         if ($urandom_range(599) == 0) begin
            rst_n = 0;
            tick();
            rst_n = 1;
         end
         ev(c, b, s, it, cv, ct);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
